// File: rtl/dbg_mem_responder.sv
// dbg_mem_responder: byte-stream debug responder for the data RAM debug port.
// Collects READ / WRITE / DUMP commands from a byte link, performs the RAM
// accesses one at a time and streams the response bytes back to the host.
module dbg_mem_responder #(
    parameter int RAMDEPTH  = 1024,
    parameter int ADDRWIDTH = 16
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic                 busy
);

    // Opcode as stored internally (low two bits of the command byte).
    localparam logic [1:0]  OP_READ  = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;
    localparam logic [1:0]  OP_DUMP  = 2'd3;
    localparam logic [7:0]  RSP_ACK  = 8'hA5;
    localparam logic [7:0]  RSP_ERR  = 8'hEE;
    // 17-bit depth so address + count can never wrap during the range check.
    localparam logic [16:0] DEPTH17  = 17'(RAMDEPTH);

    typedef enum logic [4:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_WD0,
        S_WD1,
        S_WD2,
        S_WD3,
        S_CHECK,
        S_MEM_RD,
        S_MEM_WAIT,
        S_MEM_WR,
        S_TX_B0,
        S_TX_B1,
        S_TX_B2,
        S_TX_B3,
        S_TX_ACK,
        S_TX_ERR
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_live;        // low during reset, high from the first edge after release
    logic [1:0]             r_op;
    logic [15:0]            r_addr;
    logic [15:0]            r_cnt;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [ADDRWIDTH-1:0]   r_mem_addr;
    logic [31:0]            r_mem_wdata;

    logic                   w_collect;
    logic                   w_tx_state;
    logic                   w_rx_fire;
    logic                   w_tx_fire;
    logic                   w_op_valid;
    logic [16:0]            w_addr_ext;
    logic [16:0]            w_end_ext;
    logic                   w_addr_bad;
    logic                   w_dump_bad;
    logic [7:0]             w_rd_byte [4];
    logic [7:0]             w_tx_byte;

    // Read data split into bytes; the response sends byte 0 first.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign w_rd_byte[gi] = r_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_collect  = r_state inside {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
                                        S_WD0, S_WD1, S_WD2, S_WD3};
    assign w_tx_state = r_state inside {S_TX_B0, S_TX_B1, S_TX_B2, S_TX_B3, S_TX_ACK, S_TX_ERR};

    assign rx_ready  = r_live & w_collect;
    assign tx_valid  = w_tx_state;
    assign tx_data   = w_tx_byte;
    assign w_rx_fire = rx_valid & rx_ready;
    assign w_tx_fire = tx_valid & tx_ready;

    assign mem_req   = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign mem_we    = (r_state == S_MEM_WR);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

    assign w_op_valid = (rx_data == 8'h01) || (rx_data == 8'h02) || (rx_data == 8'h03);
    assign w_addr_ext = {1'b0, r_addr};
    assign w_end_ext  = w_addr_ext + {1'b0, r_cnt};
    assign w_addr_bad = (w_addr_ext >= DEPTH17);
    assign w_dump_bad = (w_end_ext > DEPTH17);

    // Response byte selection; zero whenever nothing is being offered.
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            S_TX_B0:  w_tx_byte = w_rd_byte[0];
            S_TX_B1:  w_tx_byte = w_rd_byte[1];
            S_TX_B2:  w_tx_byte = w_rd_byte[2];
            S_TX_B3:  w_tx_byte = w_rd_byte[3];
            S_TX_ACK: w_tx_byte = RSP_ACK;
            S_TX_ERR: w_tx_byte = RSP_ERR;
            default:  w_tx_byte = 8'h00;
        endcase
    end

    // Next-state logic: command collection, range check, access, response.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_rx_fire) w_state_next = w_op_valid ? S_ADDR_HI : S_TX_ERR;
            S_ADDR_HI: if (w_rx_fire) w_state_next = S_ADDR_LO;
            S_ADDR_LO: begin
                if (w_rx_fire) begin
                    case (r_op)
                        OP_WRITE: w_state_next = S_WD0;
                        OP_DUMP:  w_state_next = S_CNT_HI;
                        default:  w_state_next = S_CHECK;
                    endcase
                end
            end
            S_CNT_HI:  if (w_rx_fire) w_state_next = S_CNT_LO;
            S_CNT_LO:  if (w_rx_fire) w_state_next = S_CHECK;
            S_WD0:     if (w_rx_fire) w_state_next = S_WD1;
            S_WD1:     if (w_rx_fire) w_state_next = S_WD2;
            S_WD2:     if (w_rx_fire) w_state_next = S_WD3;
            S_WD3:     if (w_rx_fire) w_state_next = S_CHECK;
            S_CHECK: begin
                case (r_op)
                    OP_READ:  w_state_next = w_addr_bad ? S_TX_ERR : S_MEM_RD;
                    OP_WRITE: w_state_next = w_addr_bad ? S_TX_ERR : S_MEM_WR;
                    OP_DUMP: begin
                        if (w_dump_bad)
                            w_state_next = S_TX_ERR;
                        else if (r_cnt == 16'd0)
                            w_state_next = S_TX_ACK;
                        else
                            w_state_next = S_MEM_RD;
                    end
                    default:  w_state_next = S_TX_ERR;
                endcase
            end
            S_MEM_RD:   w_state_next = S_MEM_WAIT;
            S_MEM_WAIT: w_state_next = S_TX_B0;
            S_MEM_WR:   w_state_next = S_TX_ACK;
            S_TX_B0:    if (w_tx_fire) w_state_next = S_TX_B1;
            S_TX_B1:    if (w_tx_fire) w_state_next = S_TX_B2;
            S_TX_B2:    if (w_tx_fire) w_state_next = S_TX_B3;
            S_TX_B3: begin
                if (w_tx_fire) begin
                    if (r_op == OP_DUMP)
                        w_state_next = (r_cnt != 16'd0) ? S_MEM_RD : S_TX_ACK;
                    else
                        w_state_next = S_IDLE;
                end
            end
            S_TX_ACK:   if (w_tx_fire) w_state_next = S_IDLE;
            S_TX_ERR:   if (w_tx_fire) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // State register plus command fields, read capture and the held memory port.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_op        <= 2'd0;
            r_addr      <= 16'd0;
            r_cnt       <= 16'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_rx_fire) begin
                case (r_state)
                    S_IDLE:    r_op         <= rx_data[1:0];
                    S_ADDR_HI: r_addr[15:8] <= rx_data;
                    S_ADDR_LO: r_addr[7:0]  <= rx_data;
                    S_CNT_HI:  r_cnt[15:8]  <= rx_data;
                    S_CNT_LO:  r_cnt[7:0]   <= rx_data;
                    // Data arrives least significant byte first: shift in from the top.
                    S_WD0, S_WD1, S_WD2, S_WD3: r_wdata <= {rx_data, r_wdata[31:8]};
                    default: ;
                endcase
            end
            // Each issued read advances the dump window by one word.
            if (r_state == S_MEM_RD) begin
                r_addr <= r_addr + 16'd1;
                r_cnt  <= r_cnt - 16'd1;
            end
            if (r_state == S_MEM_WAIT)
                r_rdata <= mem_rdata;
            // Address/data are latched as the access starts and held until the next one.
            if (w_state_next == S_MEM_RD || w_state_next == S_MEM_WR)
                r_mem_addr <= ADDRWIDTH'(r_addr);
            if (w_state_next == S_MEM_WR)
                r_mem_wdata <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dbg_mem_responder.sv
// Directed bench for dbg_mem_responder with a behavioural RAM on the debug port
// and a queue of expected response bytes.
module tb_dbg_mem_responder;

    localparam int RAMDEPTH  = 1024;
    localparam int ADDRWIDTH = 16;

    logic                 clock = 1'b0;
    logic                 nreset;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 busy;

    always #5 clock = ~clock;

    dbg_mem_responder #(
        .RAMDEPTH  (RAMDEPTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural RAM: read data appears one cycle after the request.
    logic [31:0]          ram [RAMDEPTH];
    logic [ADDRWIDTH-1:0] req_addr_q [$];
    logic                 req_we_q   [$];
    logic [31:0]          req_wd_q   [$];

    always @(posedge clock) begin
        if (mem_req) begin
            req_addr_q.push_back(mem_addr);
            req_we_q.push_back(mem_we);
            req_wd_q.push_back(mem_wdata);
            if (mem_we)
                ram[mem_addr[9:0]] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    logic [7:0] cmd_q [$];
    logic [7:0] exp_q [$];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic clear_reqs();
        req_addr_q.delete();
        req_we_q.delete();
        req_wd_q.delete();
    endtask

    task automatic check_reqs(input int n, input logic we, input logic [15:0] a0);
        check("req_count", 32'(req_addr_q.size()), 32'(n));
        for (int i = 0; i < req_addr_q.size() && i < n; i++) begin
            check("req_addr", 32'(req_addr_q[i]), 32'(a0) + 32'(i));
            check("req_we", 32'(req_we_q[i]), 32'(we));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Wait for one response byte; lat>0 checks the cycles from the last command byte.
    task automatic recv_byte(input int hold, input int lat);
        int         w;
        logic [7:0] held;
        logic [7:0] e;
        tx_ready = (hold == 0);
        w = 1;
        @(negedge clock);
        while (!tx_valid && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("tx_valid_wait", 32'(tx_valid), 32'd1);
        if (lat > 0) check("first_tx_latency", 32'(w), 32'(lat));
        if (hold > 0) begin
            held = tx_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                check("bp_tx_valid", 32'(tx_valid), 32'd1);
                check("bp_tx_stable", 32'(tx_data), 32'(held));
                check("bp_rx_ready", 32'(rx_ready), 32'd0);
            end
            tx_ready = 1'b1;
        end
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e));
        @(posedge clock);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic run_cmd(input int hold, input int lat);
        int n;
        clear_reqs();
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
        n = exp_q.size();
        for (int k = 0; k < n; k++) recv_byte(hold, (k == 0) ? lat : 0);
        check("busy_end", 32'(busy), 32'd0);
        check("rx_ready_end", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        logic [15:0] wr_addr [4];
        logic [31:0] wr_data [4];
        wr_addr = '{16'd2, 16'd3, 16'd4, 16'd1023};
        wr_data = '{32'd1, 32'd2, 32'd3, 32'hCAFEF00D};

        nreset   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        nreset = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // WRITE 0x12345678 to word 5
        cmd_q = '{8'h02, 8'h00, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12};
        exp_q = '{8'hA5};
        run_cmd(0, 3);
        check_reqs(1, 1'b1, 16'd5);
        if (req_wd_q.size() > 0) check("write_wdata", req_wd_q[0], 32'h12345678);
        check("held_mem_addr", 32'(mem_addr), 32'd5);
        check("held_mem_wdata", mem_wdata, 32'h12345678);

        // READ word 5
        cmd_q = '{8'h01, 8'h00, 8'h05};
        push_word(32'h12345678);
        run_cmd(0, 4);
        check_reqs(1, 1'b0, 16'd5);

        // Seed words for the dump tests
        for (int i = 0; i < 4; i++) begin
            a = wr_addr[i];
            d = wr_data[i];
            cmd_q = '{8'h02, a[15:8], a[7:0], d[7:0], d[15:8], d[23:16], d[31:24]};
            exp_q = '{8'hA5};
            run_cmd(0, 3);
            check_reqs(1, 1'b1, a);
        end

        // DUMP words 2..4
        cmd_q = '{8'h03, 8'h00, 8'h02, 8'h00, 8'h03};
        push_word(32'd1);
        push_word(32'd2);
        push_word(32'd3);
        exp_q.push_back(8'hA5);
        run_cmd(0, 4);
        check_reqs(3, 1'b0, 16'd2);

        // DUMP ending exactly at the last word
        cmd_q = '{8'h03, 8'h03, 8'hFF, 8'h00, 8'h01};
        push_word(32'hCAFEF00D);
        exp_q.push_back(8'hA5);
        run_cmd(0, 4);
        check_reqs(1, 1'b0, 16'd1023);

        // DUMP with zero count
        cmd_q = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
        exp_q = '{8'hA5};
        run_cmd(0, 2);
        check_reqs(0, 1'b0, 16'd0);

        // READ out of range
        cmd_q = '{8'h01, 8'h04, 8'h00};
        exp_q = '{8'hEE};
        run_cmd(0, 2);
        check_reqs(0, 1'b0, 16'd0);

        // DUMP running one past the end
        cmd_q = '{8'h03, 8'h03, 8'hFF, 8'h00, 8'h02};
        exp_q = '{8'hEE};
        run_cmd(0, 2);
        check_reqs(0, 1'b0, 16'd0);

        // WRITE out of range: data bytes consumed, then error
        cmd_q = '{8'h02, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{8'hEE};
        run_cmd(0, 2);
        check_reqs(0, 1'b0, 16'd0);

        // Unknown opcode
        cmd_q = '{8'h07};
        exp_q = '{8'hEE};
        run_cmd(0, 1);
        check_reqs(0, 1'b0, 16'd0);

        // Normal READ after errors
        cmd_q = '{8'h01, 8'h00, 8'h03};
        push_word(32'd2);
        run_cmd(0, 4);
        check_reqs(1, 1'b0, 16'd3);

        // READ with tx backpressure on every byte
        cmd_q = '{8'h01, 8'h00, 8'h05};
        push_word(32'h12345678);
        run_cmd(5, 4);
        check_reqs(1, 1'b0, 16'd5);

        // Reset in the middle of a WRITE to word 5
        clear_reqs();
        cmd_q = '{8'h02, 8'h00, 8'h05, 8'hAA, 8'hBB};
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
        nreset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rx_ready", 32'(rx_ready), 32'd0);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        repeat (3) @(posedge clock);
        #2;
        nreset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_rx_ready_after", 32'(rx_ready), 32'd1);
        check_reqs(0, 1'b0, 16'd0);

        // Word 5 keeps its previous contents
        cmd_q = '{8'h01, 8'h00, 8'h05};
        push_word(32'h12345678);
        run_cmd(0, 4);
        check_reqs(1, 1'b0, 16'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
